// File: rtl/mmem_wb_pkg.sv
// mmem_wb_pkg: shared CADR4 M-memory widths and writer state encodings
package mmem_wb_pkg;
    localparam int M_ADDR_WIDTH = 5;
    localparam int M_DATA_WIDTH = 32;
    typedef enum logic {WB_CLR = 1'b0, WB_RUN = 1'b1} wb_state_t;
endpackage

// File: rtl/mmem_wb_fwd.sv
// mmem_wb_fwd: M-source forward select and registered pass-around data
module mmem_wb_fwd import mmem_wb_pkg::*; #(
    parameter int ADDR_WIDTH = M_ADDR_WIDTH,
    parameter int DATA_WIDTH = M_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] rd_adr,
    input  logic                  pend_v,
    input  logic [ADDR_WIDTH-1:0] pend_adr,
    input  logic [DATA_WIDTH-1:0] pend_l,
    input  logic [DATA_WIDTH-1:0] mmem_q,
    output logic [DATA_WIDTH-1:0] m_out
);
    logic                  fwd_sel_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic                  wb_hit;
    logic                  pend_hit;
    assign wb_hit   = wb_req && wb_adr == rd_adr;
    assign pend_hit = pend_v && pend_adr == rd_adr;
    assign m_out    = fwd_sel_q ? fwd_data_q : mmem_q;
    // capture the youngest matching unwritten result on each issued read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_sel_q  <= 1'b1;
            fwd_data_q <= '0;
        end else if (issue) begin
            fwd_sel_q  <= wb_hit || pend_hit;
            fwd_data_q <= wb_hit ? wb_data : pend_l;
        end
    end
endmodule

// File: rtl/mmem_wb.sv
// mmem_wb: M-memory write-back buffer, address arbiter and zero-fill sequencer
module mmem_wb import mmem_wb_pkg::*; #(
    parameter int ADDR_WIDTH     = M_ADDR_WIDTH,
    parameter int DATA_WIDTH     = M_DATA_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_adr,
    input  logic [DATA_WIDTH-1:0] mmem_q,
    output logic [ADDR_WIDTH-1:0] madr,
    output logic                  mrp,
    output logic                  mwp,
    output logic [DATA_WIDTH-1:0] l,
    output logic [DATA_WIDTH-1:0] m_out,
    output logic                  stall,
    output logic                  busy
);
    wb_state_t             state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  pend_v;
    logic [ADDR_WIDTH-1:0] pend_adr;
    logic [DATA_WIDTH-1:0] pend_l;
    logic                  in_run;
    logic                  same;
    logic                  retire;
    logic                  issue;
    assign in_run = state == WB_RUN && !reset;
    assign same   = rd_adr == pend_adr;
    assign retire = in_run && pend_v && (!rd_en || same || wb_req);
    assign stall  = retire && rd_en && !same;
    assign issue  = in_run && rd_en && !stall;
    assign busy   = reset || state == WB_CLR;
    assign madr   = reset ? '0 : !in_run ? cnt : retire ? pend_adr : rd_adr;
    assign mwp    = !reset && (!in_run || retire);
    assign mrp    = issue;
    assign l      = retire ? pend_l : '0;
    // zero-fill sequencing, then accept every result into the one-deep buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? WB_CLR : WB_RUN;
            cnt      <= '0;
            pend_v   <= 1'b0;
            pend_adr <= '0;
            pend_l   <= '0;
        end else if (state == WB_CLR) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) state <= WB_RUN;
        end else if (wb_req) begin
            pend_v   <= 1'b1;
            pend_adr <= wb_adr;
            pend_l   <= wb_data;
        end else if (retire) begin
            pend_v <= 1'b0;
        end
    end
    mmem_wb_fwd #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .wb_req   (wb_req),
        .wb_adr   (wb_adr),
        .wb_data  (wb_data),
        .rd_adr   (rd_adr),
        .pend_v   (pend_v),
        .pend_adr (pend_adr),
        .pend_l   (pend_l),
        .mmem_q   (mmem_q),
        .m_out    (m_out)
    );
endmodule

// File: tb/tb_mmem_wb.sv
// tb_mmem_wb: directed test of mmem_wb against a behavioural 32x32 M-memory
module tb_mmem_wb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_req = 1'b0;
    logic [4:0]  wb_adr = '0;
    logic [31:0] wb_data = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_adr = '0;
    logic [31:0] mmem_q = 32'hCAFE_F00D;
    logic [4:0]  madr;
    logic        mrp;
    logic        mwp;
    logic [31:0] l;
    logic [31:0] m_out;
    logic        stall;
    logic        busy;
    logic [31:0] mem [32] = '{default: 32'hBAD0_BAD0};
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // M-memory model: registered read, read-before-write on the shared address
    always @(posedge clk) begin
        if (mrp) mmem_q <= mem[madr];
        if (mwp) mem[madr] <= l;
    end

    mmem_wb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .wb_req  (wb_req),
        .wb_adr  (wb_adr),
        .wb_data (wb_data),
        .rd_en   (rd_en),
        .rd_adr  (rd_adr),
        .mmem_q  (mmem_q),
        .madr    (madr),
        .mrp     (mrp),
        .mwp     (mwp),
        .l       (l),
        .m_out   (m_out),
        .stall   (stall),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r, input logic [4:0] ra);
        wb_req = w; wb_adr = wa; wb_data = wd; rd_en = r; rd_adr = ra;
        #1;
    endtask

    task automatic clr_seq();
        for (int i = 0; i < 32; i++) begin
            chk("clr_madr", 32'(madr), i);
            chk("clr_mwp", 32'(mwp), 1);
            chk("clr_l", l, 0);
            chk("clr_busy", 32'(busy), 1);
            chk("clr_mrp", 32'(mrp), 0);
            chk("clr_stall", 32'(stall), 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("run_busy", 32'(busy), 0);
        chk("run_mwp", 32'(mwp), 0);
    endtask

    task automatic reset_checks();
        chk("rst_mwp", 32'(mwp), 0);
        chk("rst_mrp", 32'(mrp), 0);
        chk("rst_madr", 32'(madr), 0);
        chk("rst_l", l, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_m_out", m_out, 0);
    endtask

    initial begin
        // reset held, inputs active must not leak out
        drive(1, 9, 32'h1234, 1, 3);
        tick(); tick();
        reset_checks();
        reset = 1'b0;
        #1;
        // zero-fill with inputs ignored
        clr_seq();
        // read address 7 -> zero
        drive(0, 0, 0, 1, 7);
        chk("rd7_mrp", 32'(mrp), 1);
        chk("rd7_madr", 32'(madr), 7);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("rd7_m_out", m_out, 0);
        // write 5, retire on idle cycle, read back from memory
        drive(1, 5, 32'hDEAD_BEEF, 0, 0);
        chk("wb5_no_retire", 32'(mwp), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("wb5_mwp", 32'(mwp), 1);
        chk("wb5_madr", 32'(madr), 5);
        chk("wb5_l", l, 32'hDEAD_BEEF);
        tick();
        drive(0, 0, 0, 1, 5);
        chk("rd5_mrp", 32'(mrp), 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("rd5_m_out", m_out, 32'hDEAD_BEEF);
        // same-cycle forward from wb_data
        drive(1, 3, 32'h11, 1, 3);
        chk("fw11_stall", 32'(stall), 0);
        chk("fw11_mrp", 32'(mrp), 1);
        tick();
        drive(1, 3, 32'h22, 0, 0);
        chk("fw11_m_out", m_out, 32'h11);
        chk("ret11_mwp", 32'(mwp), 1);
        chk("ret11_l", l, 32'h11);
        tick();
        // read of pending address retires and forwards
        drive(0, 0, 0, 1, 3);
        chk("fw22_mwp", 32'(mwp), 1);
        chk("fw22_madr", 32'(madr), 3);
        chk("fw22_l", l, 32'h22);
        chk("fw22_mrp", 32'(mrp), 1);
        chk("fw22_stall", 32'(stall), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("fw22_m_out", m_out, 32'h22);
        // stall: pending 4/AA, new write 9/BB with read of 6
        drive(1, 4, 32'hAA, 0, 0);
        tick();
        drive(1, 9, 32'hBB, 1, 6);
        chk("st_stall", 32'(stall), 1);
        chk("st_mwp", 32'(mwp), 1);
        chk("st_madr", 32'(madr), 4);
        chk("st_l", l, 32'hAA);
        chk("st_mrp", 32'(mrp), 0);
        tick();
        drive(0, 0, 0, 1, 6);
        chk("st_hold_m_out", m_out, 32'h22);
        chk("st_rep_stall", 32'(stall), 0);
        chk("st_rep_mrp", 32'(mrp), 1);
        chk("st_rep_madr", 32'(madr), 6);
        chk("st_rep_mwp", 32'(mwp), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("st_rd6_m_out", m_out, 0);
        chk("ret9_mwp", 32'(mwp), 1);
        chk("ret9_madr", 32'(madr), 9);
        chk("ret9_l", l, 32'hBB);
        tick();
        // continuous reads elsewhere defer pending 2
        drive(1, 2, 32'h5A5A, 0, 0);
        tick();
        drive(0, 0, 0, 1, 10);
        chk("def10_mwp", 32'(mwp), 0);
        chk("def10_stall", 32'(stall), 0);
        chk("def10_mrp", 32'(mrp), 1);
        tick();
        drive(0, 0, 0, 1, 9);
        chk("def9_mwp", 32'(mwp), 0);
        chk("def9_stall", 32'(stall), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("def9_m_out", m_out, 32'hBB);
        chk("ret2_mwp", 32'(mwp), 1);
        chk("ret2_madr", 32'(madr), 2);
        chk("ret2_l", l, 32'h5A5A);
        tick();
        // reset mid-RUN then again at CLR cnt=17
        reset = 1'b1;
        #1;
        reset_checks();
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 17; i++) tick();
        chk("c17_madr", 32'(madr), 17);
        reset = 1'b1;
        #1;
        reset_checks();
        tick();
        reset = 1'b0;
        #1;
        clr_seq();
        // reset with a pending write: it is discarded
        drive(1, 12, 32'h77, 0, 0);
        tick();
        drive(0, 0, 0, 1, 20);
        reset = 1'b1;
        #1;
        reset_checks();
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        clr_seq();
        drive(0, 0, 0, 1, 12);
        chk("rd12_mwp", 32'(mwp), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("rd12_m_out", m_out, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
